winograd_operand_loader: RTL and testbench

Upstream feeder for winograd_conv_10x12. Accepts one operand frame as a valid/ready word stream (kernel words, then image words, row-major). Assembles the words into the parallel kernel_out[3][3] and image_out[10][12] arrays, then pulses conv_start. Holds both arrays stable until the convolution core reports conv_done, because the core re-reads its inputs across tile rounds.

---
 rtl/winograd_pkg.sv | 33 +++
 rtl/winograd_operand_loader.sv | 156 +++++++++++++++
 tb/tb_winograd_operand_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// Shared types and geometry for the Winograd 10x12 convolution datapath.
package winograd_pkg;

    localparam int IMG_ROWS = 10;
    localparam int IMG_COLS = 12;
    localparam int K        = 3;
    localparam int OUT_ROWS = IMG_ROWS - 2;
    localparam int OUT_COLS = IMG_COLS - 2;
    localparam int DATA_W   = 32;

    localparam int ROW_W  = $clog2(IMG_ROWS);
    localparam int COL_W  = $clog2(IMG_COLS);
    localparam int KIDX_W = $clog2(K);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [KIDX_W-1:0] kidx_t;

    localparam row_t  LAST_ROW = row_t'(IMG_ROWS - 1);
    localparam col_t  LAST_COL = col_t'(IMG_COLS - 1);
    localparam kidx_t K_LAST   = kidx_t'(K - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KERNEL = 3'd1,
        ST_IMAGE  = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/winograd_operand_loader.sv
// Collects one kernel+image frame from a valid/ready word stream into the
// parallel operand arrays of the Winograd core, starts the core, and keeps the
// operands frozen until the core reports completion.
module winograd_operand_loader
    import winograd_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t s_data,
    input  logic  s_valid,
    input  logic  s_last,
    output logic  s_ready,
    input  logic  reuse_kernel,
    output word_t kernel_out [K][IMG_ROWS > 0 ? K : K],
    output word_t image_out  [IMG_ROWS][IMG_COLS],
    output logic  conv_start,
    input  logic  conv_done,
    output logic  busy,
    output logic  err_len
);

    loader_state_e state_q, state_d;
    logic          kv_q, kv_d;
    logic          err_q, err_d;
    kidx_t         krow_q, kcol_q;
    row_t          row_q;
    col_t          col_q;
    word_t         kernel_q [K][K];
    word_t         image_q  [IMG_ROWS][IMG_COLS];

    logic beat;
    logic k_last_word;
    logic img_last_word;

    assign beat          = s_valid & s_ready;
    assign k_last_word   = (krow_q == K_LAST) && (kcol_q == K_LAST);
    assign img_last_word = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // State, kernel-valid flag and length-error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, including frame-length checking on s_last
    always_comb begin
        state_d = state_q;
        kv_d    = kv_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Reuse only helps when a complete kernel is actually held
                state_d = (reuse_kernel && kv_q) ? ST_IMAGE : ST_KERNEL;
            end
            ST_KERNEL: begin
                if (beat) begin
                    if (s_last) begin
                        // Kernel words never end a frame; the partial kernel is untrustworthy
                        err_d   = 1'b1;
                        kv_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else if (k_last_word) begin
                        kv_d    = 1'b1;
                        state_d = ST_IMAGE;
                    end
                end
            end
            ST_IMAGE: begin
                if (beat) begin
                    if (img_last_word) begin
                        if (s_last) begin
                            state_d = ST_START;
                        end else begin
                            // Frame is longer than expected: swallow the rest up to s_last
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (conv_done) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (beat && s_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        s_ready    = 1'b0;
        conv_start = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_KERNEL, ST_IMAGE, ST_DRAIN: s_ready    = 1'b1;
            ST_START:                      conv_start = 1'b1;
            default: ;
        endcase
    end

    assign err_len = err_q;

    // Word placement counters and operand arrays; arrays change only on beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            krow_q <= '0;
            kcol_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    kernel_q[r][c] <= '0;
            for (int r = 0; r < IMG_ROWS; r++)
                for (int c = 0; c < IMG_COLS; c++)
                    image_q[r][c] <= '0;
        end else if (state_q == ST_IDLE) begin
            krow_q <= '0;
            kcol_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (beat && state_q == ST_KERNEL) begin
            kernel_q[krow_q][kcol_q] <= s_data;
            if (kcol_q == K_LAST) begin
                kcol_q <= '0;
                krow_q <= krow_q + kidx_t'(1);
            end else begin
                kcol_q <= kcol_q + kidx_t'(1);
            end
        end else if (beat && state_q == ST_IMAGE) begin
            image_q[row_q][col_q] <= s_data;
            if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + row_t'(1);
            end else begin
                col_q <= col_q + col_t'(1);
            end
        end
    end

    assign kernel_out = kernel_q;
    assign image_out  = image_q;

endmodule

// File: tb/tb_winograd_operand_loader.sv
// Randomized bench for winograd_operand_loader with a frame-level reference model.
module tb_winograd_operand_loader;
    import winograd_pkg::*;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_START = 2;
    localparam int P_WAIT  = 3;
    localparam int P_DRAIN = 4;

    logic  clk = 1'b0;
    logic  rst;
    word_t s_data;
    logic  s_valid, s_last, s_ready, reuse_kernel;
    word_t kernel_out [K][K];
    word_t image_out  [IMG_ROWS][IMG_COLS];
    logic  conv_start, conv_done, busy, err_len;

    winograd_operand_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .reuse_kernel (reuse_kernel),
        .kernel_out   (kernel_out),
        .image_out    (image_out),
        .conv_start   (conv_start),
        .conv_done    (conv_done),
        .busy         (busy),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: position in frame, expected frame length, kernel-held flag
    int          m_phase;
    int          m_pos;
    int          m_len;
    logic        m_kv;
    logic        m_err;
    logic [31:0] mk [K][K];
    logic [31:0] mi [IMG_ROWS][IMG_COLS];
    logic        last_beat;
    logic [31:0] dat [0:255];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int ph);
        return (ph == P_LOAD) || (ph == P_DRAIN);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pos   = 0;
        m_len   = 129;
        m_kv    = 1'b0;
        m_err   = 1'b0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) mk[r][c] = '0;
        for (int r = 0; r < IMG_ROWS; r++)
            for (int c = 0; c < IMG_COLS; c++) mi[r][c] = '0;
    endtask

    task automatic check_arrays(input string tag);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                chk({tag, "_kernel"}, kernel_out[r][c], mk[r][c]);
        for (int r = 0; r < IMG_ROWS; r++)
            for (int c = 0; c < IMG_COLS; c++)
                chk({tag, "_image"}, image_out[r][c], mi[r][c]);
    endtask

    task automatic check_ctrl();
        chk("s_ready",    s_ready,    ready_of(m_phase));
        chk("conv_start", conv_start, m_phase == P_START);
        chk("busy",       busy,       m_phase != P_IDLE);
        chk("err_len",    err_len,    m_err);
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare
    task automatic tick();
        logic rdy;
        logic bt;
        int   p;
        int   q;
        rdy = ready_of(m_phase);
        @(posedge clk);
        bt        = s_valid && rdy;
        last_beat = bt;
        m_err     = 1'b0;
        case (m_phase)
            P_IDLE: begin
                m_len   = (reuse_kernel && m_kv) ? 120 : 129;
                m_pos   = 0;
                m_phase = P_LOAD;
            end
            P_LOAD: if (bt) begin
                p = m_pos;
                if (m_len == 129 && p < 9) mk[p / 3][p % 3] = s_data;
                else begin
                    q = (m_len == 129) ? p - 9 : p;
                    mi[q / 12][q % 12] = s_data;
                end
                if (p == m_len - 1) begin
                    if (s_last) m_phase = P_START;
                    else begin
                        m_err   = 1'b1;
                        m_phase = P_DRAIN;
                    end
                end else if (s_last) begin
                    m_err   = 1'b1;
                    m_phase = P_IDLE;
                    if (m_len == 129 && p < 9) m_kv = 1'b0;
                end else begin
                    if (m_len == 129 && p == 8) m_kv = 1'b1;
                    m_pos++;
                end
            end
            P_START: m_phase = P_WAIT;
            P_WAIT:  if (conv_done) m_phase = P_IDLE;
            P_DRAIN: if (bt && s_last) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
        #1;
        check_ctrl();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_ctrl();
        check_arrays("reset");
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sends nwords words (s_last on index last_at), optionally random data and
    // valid gaps, answers conv_done after done_delay wait cycles; rst_at>=0
    // fires an asynchronous reset when that word index is about to be sent.
    task automatic run_frame(input int nwords, input int last_at, input logic reuse,
                             input int base, input bit rnd, input int gap_pct,
                             input int done_delay, input int rst_at);
        int   widx;
        int   waitcnt;
        int   cyc;
        logic done;
        widx    = 0;
        waitcnt = 0;
        cyc     = 0;
        done    = 1'b0;
        for (int i = 0; i < nwords; i++) dat[i] = rnd ? $urandom : 32'(base + i);
        reuse_kernel = reuse;
        while (!done && cyc < 4000) begin
            if (rst_at >= 0 && widx == rst_at && m_phase == P_LOAD) begin
                do_reset();
                return;
            end
            if (widx < nwords) begin
                s_valid = ($urandom_range(99) >= gap_pct);
                s_data  = dat[widx];
                s_last  = (widx == last_at);
            end else begin
                s_valid = 1'($urandom_range(1));
                s_data  = $urandom;
                s_last  = 1'($urandom_range(1));
            end
            conv_done = (m_phase == P_WAIT) ? (waitcnt >= done_delay)
                                            : ($urandom_range(7) == 0);
            tick();
            if (last_beat) widx++;
            if (m_phase == P_WAIT) waitcnt++;
            cyc++;
            if (widx >= nwords && m_phase == P_IDLE) done = 1'b1;
            @(negedge clk);
        end
        chk("frame_done", done, 1'b1);
        s_valid   = 1'b0;
        s_last    = 1'b0;
        conv_done = 1'b0;
        check_arrays("frame_end");
    endtask

    initial begin
        int   len;
        int   kind;
        int   la;
        logic ru;
        rst          = 1'b1;
        s_data       = '0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        reuse_kernel = 1'b0;
        conv_done    = 1'b0;
        model_reset();
        do_reset();

        // Sequential kernel 1..9 and image 10..129, continuous valid
        run_frame(129, 128, 1'b0, 1, 1'b0, 0, 0, -1);
        chk("t1_k22",  kernel_out[2][2], 32'd9);
        chk("t1_i00",  image_out[0][0],  32'd10);
        chk("t1_i911", image_out[9][11], 32'd129);

        // Same frame with valid gaps and a long wait for conv_done
        run_frame(129, 128, 1'b0, 1, 1'b0, 50, 500, -1);

        // Image-only frame reusing the held kernel
        run_frame(120, 119, 1'b1, 1000, 1'b0, 0, 3, -1);
        chk("t3_k00",  kernel_out[0][0], 32'd1);
        chk("t3_i00",  image_out[0][0],  32'd1000);
        chk("t3_i911", image_out[9][11], 32'd1119);

        // Early s_last on word 50, then a good random frame
        run_frame(50, 49, 1'b0, 0, 1'b1, 20, 0, -1);
        run_frame(129, 128, 1'b0, 0, 1'b1, 30, 5, -1);

        // Missing s_last on the final word, six trailing words drained
        run_frame(135, 134, 1'b0, 0, 1'b1, 10, 0, -1);

        // Reset at image word 60, then reuse request must load the full frame
        run_frame(129, 128, 1'b0, 0, 1'b1, 0, 0, 69);
        run_frame(129, 128, 1'b1, 2000, 1'b0, 0, 2, -1);
        chk("t6_k00", kernel_out[0][0], 32'd2000);

        // Random mix of good, short and long frames
        for (int f = 0; f < 8; f++) begin
            ru   = 1'($urandom_range(1));
            len  = (ru && m_kv) ? 120 : 129;
            kind = $urandom_range(2);
            if (kind == 0) begin
                run_frame(len, len - 1, ru, 0, 1'b1, $urandom_range(40), $urandom_range(20), -1);
            end else if (kind == 1) begin
                la = $urandom_range(len - 2);
                run_frame(la + 1, la, ru, 0, 1'b1, $urandom_range(40), 0, -1);
            end else begin
                la = len + $urandom_range(1, 5);
                run_frame(la, la - 1, ru, 0, 1'b1, $urandom_range(40), 0, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
